led_pwm_driver: RTL and testbench
=================================

# led_pwm_driver

Output conditioning stage between the 10-bit LED PIO and the board LED pins. It takes the PIO's `out_port` pattern and applies a global PWM brightness and an optional blink, then drives `led_out`. Its own Avalon-MM slave holds the control registers and sits on the same HPS lightweight bridge as the PIO.

## Interface
- `N_LEDS`, default 10: pattern and LED width.
- `PWM_BITS`, default 8: PWM counter and duty width.
- `PRESCALE_BITS`, default 16: prescaler and blink register width.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `address` in 2: register select.
- `chipselect` in 1: Avalon slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data, zero wait states, unused bits 0.
- `pattern_in` in N_LEDS: LED pattern from the PIO `out_port`.
- `led_out` out N_LEDS: registered LED drive, 1 = lit unless inverted.

## Operation
- A write is `chipselect & ~write_n`. Registers and reset values:
  - Address 0, CTRL:
    - bit0 `enable`, reset 1.
    - bit1 `blink_en`, reset 0.
    - bit2 `invert`, reset 0.
    - Bits [31:3] read 0.
  - Address 1, DUTY: [PWM_BITS-1:0], reset all-ones (255).
  - Address 2, PRESCALE: [PRESCALE_BITS-1:0], reset 0.
  - Address 3, BLINK: [PRESCALE_BITS-1:0], reset 0.
- Read: `readdata` is a combinational mux of the addressed register, zero-extended. It does not depend on `chipselect`.
- Prescaler:
  - `pre_cnt` counts 0..PRESCALE, then returns to 0.
  - `tick` = (`pre_cnt` == PRESCALE). With PRESCALE = 0, tick is asserted every cycle.
- PWM:
  - `pwm_cnt` increments on each tick and wraps from 2^PWM_BITS-1 to 0.
  - `wrap` = tick & (`pwm_cnt` all-ones).
  - `pwm_on` = (DUTY all-ones) | (`pwm_cnt` < DUTY). DUTY 0 gives always off; DUTY 255 gives always on.
- Blink:
  - Effective period `bp` = max(BLINK, 1).
  - On each `wrap`: if `blink_cnt` ≥ `bp`-1, toggle `blink_phase` and clear `blink_cnt`; otherwise increment `blink_cnt`.
  - While `blink_en` = 0: `blink_cnt` = 0 and `blink_phase` = 1.
- Pattern capture:
  - `pattern_q` loads `pattern_in` on each `wrap`, so each PWM period shows a whole, consistent pattern.
  - `pattern_q` reset value is all-ones, matching the PIO reset value.
- Output: `led_out` <= (enable ? `pattern_q` & {N{`pwm_on` & `blink_phase`}} : 0) ^ {N{invert}}.
- Write side effects:
  - A write to PRESCALE clears `pre_cnt` and `pwm_cnt`.
  - A write to BLINK clears `blink_cnt`.
  - A write to CTRL that sets `blink_en` from 0 to 1 starts with phase 1 and count 0.
- Simultaneous events: a write-side clear overrides a same-cycle tick or wrap increment.
- Asynchronous reset returns all registers and counters to their reset values at any time, including mid-period. `led_out` resets to 0.

## Timing
- A register write at edge k takes effect in the `led_out` computation at edge k+1.
- Output latency: `led_out` is registered one cycle after `pwm_on`, `blink_phase` and `pattern_q` are evaluated.
- Pattern latency: a `pattern_in` change is visible after the next `wrap`, which is at most 2^PWM_BITS·(PRESCALE+1) cycles, plus one cycle for the output register.
- PWM period = 2^PWM_BITS·(PRESCALE+1) cycles. Blink half-period = `bp` PWM periods.
- First edge after reset release: `led_out` = 0x3FF (enable = 1, DUTY = 255, phase = 1, pattern all-ones).

## Test plan
- Reset, then idle for 2 cycles -> `led_out` = 0x000 during reset and 0x3FF at the first edge after release. Reads: addr0 = 0x1, addr1 = 0xFF, addr2 = 0, addr3 = 0.
- `pattern_in` = 0x155 with PRESCALE = 0 -> `led_out` becomes 0x155 within 257 cycles, with no intermediate value.
- DUTY = 64, PRESCALE = 0, pattern 0x3FF -> `led_out` = 0x3FF for exactly 64 of every 256 cycles. DUTY = 0 -> always 0x000.
- DUTY = 255, `blink_en` = 1, BLINK = 2, PRESCALE = 0 -> `led_out` alternates between 0x3FF and 0x000 every 512 cycles. BLINK = 0 -> toggles every 256 cycles.
- CTRL = 0x4 (enable = 0, invert = 1) -> `led_out` = 0x3FF one cycle after the write. CTRL = 0x5 with pattern 0x0F0 -> `led_out` = 0x30F.
- Assert `reset_n` mid-blink while the phase is 0 with PRESCALE = 3 -> all registers and counters return to reset values and `led_out` = 0x3FF at the first edge after release.

Source files
------------

// File: rtl/led_pwm_driver.sv
// LED output conditioning: captures the PIO pattern once per PWM period and applies
// global PWM brightness, optional blink and polarity inversion before driving the pins.
module led_pwm_driver #(
   parameter int N_LEDS        = 10,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic [N_LEDS-1:0]   pattern_in,
   output logic [N_LEDS-1:0]   led_out
);

   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_DUTY     = 2'd1;
   localparam logic [1:0] ADDR_PRESCALE = 2'd2;
   localparam logic [1:0] ADDR_BLINK    = 2'd3;

   localparam logic [PRESCALE_BITS-1:0] PRE_ONE = 1;
   localparam logic [PWM_BITS-1:0]      PWM_ONE = 1;

   // Control registers
   logic                      enable_reg;
   logic                      blink_en_reg;
   logic                      invert_reg;
   logic [PWM_BITS-1:0]       duty_reg;
   logic [PRESCALE_BITS-1:0]  prescale_reg;
   logic [PRESCALE_BITS-1:0]  blink_reg;

   // Timebase and output state
   logic [PRESCALE_BITS-1:0]  pre_cnt_reg,     pre_cnt_next;
   logic [PWM_BITS-1:0]       pwm_cnt_reg,     pwm_cnt_next;
   logic [PRESCALE_BITS-1:0]  blink_cnt_reg,   blink_cnt_next;
   logic                      blink_phase_reg, blink_phase_next;
   logic [N_LEDS-1:0]         pattern_q_reg,   pattern_q_next;
   logic [N_LEDS-1:0]         led_out_reg,     led_out_next;

   logic                      wr_en;
   logic                      wr_ctrl;
   logic                      wr_duty;
   logic                      wr_prescale;
   logic                      wr_blink;
   logic                      blink_en_next;
   logic                      tick;
   logic                      wrap;
   logic                      pwm_on;
   logic                      lit;
   logic [PRESCALE_BITS-1:0]  blink_last;
   logic                      unused_wdata;

   assign wr_en       = chipselect & ~write_n;
   assign wr_ctrl     = wr_en & (address == ADDR_CTRL);
   assign wr_duty     = wr_en & (address == ADDR_DUTY);
   assign wr_prescale = wr_en & (address == ADDR_PRESCALE);
   assign wr_blink    = wr_en & (address == ADDR_BLINK);

   // Upper writedata bits beyond the widest register are deliberately ignored.
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_reg   <= 1'b1;
         blink_en_reg <= 1'b0;
         invert_reg   <= 1'b0;
         duty_reg     <= '1;
         prescale_reg <= '0;
         blink_reg    <= '0;
      end else begin
         if (wr_ctrl) begin
            enable_reg   <= writedata[0];
            blink_en_reg <= writedata[1];
            invert_reg   <= writedata[2];
         end
         if (wr_duty) begin
            duty_reg <= writedata[PWM_BITS-1:0];
         end
         if (wr_prescale) begin
            prescale_reg <= writedata[PRESCALE_BITS-1:0];
         end
         if (wr_blink) begin
            blink_reg <= writedata[PRESCALE_BITS-1:0];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:     readdata[2:0]               = {invert_reg, blink_en_reg, enable_reg};
         ADDR_DUTY:     readdata[PWM_BITS-1:0]      = duty_reg;
         ADDR_PRESCALE: readdata[PRESCALE_BITS-1:0] = prescale_reg;
         default:       readdata[PRESCALE_BITS-1:0] = blink_reg;
      endcase
   end

   assign tick   = (pre_cnt_reg == prescale_reg);
   assign wrap   = tick & (&pwm_cnt_reg);
   assign pwm_on = (&duty_reg) | (pwm_cnt_reg < duty_reg);

   // A PRESCALE write restarts the whole PWM period, overriding any same-cycle tick.
   always_comb begin
      pre_cnt_next = pre_cnt_reg;
      pwm_cnt_next = pwm_cnt_reg;
      if (wr_prescale) begin
         pre_cnt_next = '0;
         pwm_cnt_next = '0;
      end else if (tick) begin
         pre_cnt_next = '0;
         pwm_cnt_next = pwm_cnt_reg + PWM_ONE;
      end else begin
         pre_cnt_next = pre_cnt_reg + PRE_ONE;
      end
   end

   assign blink_en_next = wr_ctrl ? writedata[1] : blink_en_reg;
   assign blink_last    = (blink_reg == '0) ? '0 : (blink_reg - PRE_ONE);

   // Blink state is held at phase 1 / count 0 whenever blink is off before or after this edge,
   // so disabling takes effect immediately and re-enabling always starts from a lit half-period.
   always_comb begin
      blink_cnt_next   = blink_cnt_reg;
      blink_phase_next = blink_phase_reg;
      if (!blink_en_reg || !blink_en_next) begin
         blink_cnt_next   = '0;
         blink_phase_next = 1'b1;
      end else if (wr_blink) begin
         blink_cnt_next = '0;
      end else if (wrap) begin
         if (blink_cnt_reg >= blink_last) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + PRE_ONE;
         end
      end
   end

   assign pattern_q_next = wrap ? pattern_in : pattern_q_reg;
   assign lit            = enable_reg & pwm_on & blink_phase_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N_LEDS; gi++) begin : g_led
         assign led_out_next[gi] = (lit & pattern_q_reg[gi]) ^ invert_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_reg     <= '0;
         pwm_cnt_reg     <= '0;
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b1;
         pattern_q_reg   <= '1;
         led_out_reg     <= '0;
      end else begin
         pre_cnt_reg     <= pre_cnt_next;
         pwm_cnt_reg     <= pwm_cnt_next;
         blink_cnt_reg   <= blink_cnt_next;
         blink_phase_reg <= blink_phase_next;
         pattern_q_reg   <= pattern_q_next;
         led_out_reg     <= led_out_next;
      end
   end

   assign led_out = led_out_reg;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: directed scenarios plus random register traffic, every cycle
// compared against a cycle-count based reference model of the LED output.
module tb_led_pwm_driver;

   localparam int N = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [N-1:0]  pattern_in = '1;
   logic [N-1:0]  led_out;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   led_pwm_driver dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .pattern_in (pattern_in),
      .led_out    (led_out)
   );

   // Reference model: PWM position derived from cycles since the last counter restart,
   // blink phase from the number of wraps since the last blink restart.
   int           m_cyc, m_p, m_duty, m_bl, m_w;
   bit           m_en, m_ben, m_inv, m_phase0;
   logic [N-1:0] m_pat;
   logic [N-1:0] exp_led;
   int           mt_pwm;
   bit           mt_wrap, mt_on, mt_ph, mt_old;

   function automatic bit model_phase();
      int bp;
      bp = (m_bl == 0) ? 1 : m_bl;
      return m_ben ? (m_phase0 ^ bit'((m_w / bp) % 2)) : 1'b1;
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return {29'd0, m_inv, m_ben, m_en};
         2'd1:    return 32'(m_duty);
         2'd2:    return 32'(m_p);
         default: return 32'(m_bl);
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cyc = 0; m_p = 0; m_duty = 255; m_bl = 0; m_w = 0;
         m_en = 1'b1; m_ben = 1'b0; m_inv = 1'b0; m_phase0 = 1'b1;
         m_pat = '1; exp_led = '0;
      end else begin
         mt_pwm  = (m_cyc / (m_p + 1)) % 256;
         mt_wrap = ((m_cyc + 1) % (256 * (m_p + 1))) == 0;
         mt_on   = (m_duty == 255) || (mt_pwm < m_duty);
         mt_ph   = model_phase();
         exp_led = (m_en && mt_on && mt_ph) ? m_pat : '0;
         if (m_inv) exp_led = ~exp_led;
         if (mt_wrap) begin
            m_pat = pattern_in;
            if (m_ben) m_w++;
         end
         m_cyc++;
         if (chipselect && !write_n) begin
            case (address)
               2'd0: begin
                  mt_old = m_ben;
                  m_en = writedata[0]; m_ben = writedata[1]; m_inv = writedata[2];
                  if (!mt_old || !m_ben) begin m_w = 0; m_phase0 = 1'b1; end
               end
               2'd1: m_duty = int'(writedata[7:0]);
               2'd2: begin m_p = int'(writedata[15:0]); m_cyc = 0; end
               default: begin m_phase0 = mt_ph; m_bl = int'(writedata[15:0]); m_w = 0; end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         checks++;
         assert (led_out === exp_led) else begin
            failures++;
            $error("FAIL led_model t=%0t observed=%h expected=%h", $time, led_out, exp_led);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      $display("wr addr=%0d data=%h", a, d);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp);
      address = a; chipselect = 1'($urandom_range(1));
      #1;
      $display("rd addr=%0d data=%h", a, readdata);
      chk("read", readdata, exp);
      chipselect = 1'b0;
   endtask

   task automatic count_lit(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (led_out == 10'h3FF) cnt++;
      end
   endtask

   task automatic wait_led(input logic [N-1:0] v, input int limit, output int took);
      took = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (led_out == v) begin took = i; break; end
      end
   endtask

   task automatic measure_half(input string tag, input int half);
      int t[$];
      logic [N-1:0] prev;
      prev = led_out;
      for (int i = 0; i < 3000 && t.size() < 3; i++) begin
         @(negedge clk);
         if (led_out !== prev) begin t.push_back(i); prev = led_out; end
      end
      chk({tag, "_toggles"}, 32'(t.size()), 32'd3);
      if (t.size() == 3) chk(tag, 32'(t[2] - t[1]), 32'(half));
   endtask

   initial begin
      int took, cnt, bad;
      logic [1:0] a;
      logic [31:0] d;

      // Reset and reset-value reads
      #2 reset_n = 1'b0;
      cycles(2);
      chk("reset_led", 32'(led_out), 32'h000);
      rd(2'd0, 32'h1); rd(2'd1, 32'hFF); rd(2'd2, 32'h0); rd(2'd3, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("first_edge", 32'(led_out), 32'h3FF);
      chk_on = 1'b1;
      cycles(2);

      // Pattern capture latency with no intermediate value
      pattern_in = 10'h155;
      took = -1; bad = 0;
      for (int i = 1; i <= 257; i++) begin
         @(negedge clk);
         if (led_out == 10'h155) begin took = i; break; end
         if (led_out != 10'h3FF) bad++;
      end
      chk("pattern_latency", 32'(took > 0), 32'd1);
      chk("pattern_no_glitch", 32'(bad), 32'd0);

      // Duty cycle 64/256, then 0
      pattern_in = 10'h3FF;
      wr(2'd1, 32'd64);
      cycles(260);
      count_lit(256, cnt);
      chk("duty64", 32'(cnt), 32'd64);
      wr(2'd1, 32'd0);
      cycles(2);
      count_lit(256, cnt);
      chk("duty0", 32'(cnt), 32'd0);

      // Blink half-periods
      wr(2'd1, 32'd255);
      wr(2'd0, 32'h3);
      wr(2'd3, 32'd2);
      measure_half("blink2", 512);
      wr(2'd3, 32'd0);
      measure_half("blink0", 256);

      // Inversion and disable
      wr(2'd0, 32'h4);
      @(negedge clk);
      chk("invert_disabled", 32'(led_out), 32'h3FF);
      pattern_in = 10'h0F0;
      wr(2'd0, 32'h5);
      wait_led(10'h30F, 300, took);
      chk("invert_pattern", 32'(took > 0), 32'd1);

      // Asynchronous reset in the dark blink phase
      pattern_in = 10'h3FF;
      wr(2'd0, 32'h3);
      wr(2'd3, 32'd1);
      wr(2'd2, 32'd3);
      wait_led(10'h000, 2200, took);
      chk("blink_dark_reached", 32'(took > 0), 32'd1);
      #3 reset_n = 1'b0;
      #1 chk("reset_mid_blink", 32'(led_out), 32'h000);
      rd(2'd0, 32'h1); rd(2'd1, 32'hFF); rd(2'd2, 32'h0); rd(2'd3, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("first_edge_after_midreset", 32'(led_out), 32'h3FF);

      // Random register traffic and pattern changes against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) begin
            a = 2'($urandom_range(3));
            case (a)
               2'd0:    d = $urandom;
               2'd1:    d = ($urandom_range(3) == 0) ? {$urandom_range(1) ? 8'hFF : 8'h00} : $urandom;
               2'd2:    d = 32'($urandom_range(2));
               default: d = 32'($urandom_range(3));
            endcase
            wr(a, d);
         end else begin
            if ($urandom_range(63) == 0) pattern_in = N'($urandom);
            if ($urandom_range(15) == 0) begin
               a = 2'($urandom_range(3));
               rd(a, model_read(a));
            end
            @(negedge clk);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
